// File: rtl/aes_io_pkg.sv
// Purpose : shared types and constants for the AES I/O loader.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, write/read address map, status word bit positions.
package aes_io_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_CAPTURE = 2'd2
   } state_t;

   // Write-side address map: word 0 is the most significant 32 bits.
   localparam logic [2:0] ADDR_MSG0 = 3'd0;
   localparam logic [2:0] ADDR_MSG1 = 3'd1;
   localparam logic [2:0] ADDR_MSG2 = 3'd2;
   localparam logic [2:0] ADDR_MSG3 = 3'd3;
   localparam logic [2:0] ADDR_KEY0 = 3'd4;
   localparam logic [2:0] ADDR_KEY1 = 3'd5;
   localparam logic [2:0] ADDR_KEY2 = 3'd6;
   localparam logic [2:0] ADDR_KEY3 = 3'd7;

   // Read-side address map.
   localparam logic [2:0] ADDR_RES0   = 3'd0;
   localparam logic [2:0] ADDR_RES1   = 3'd1;
   localparam logic [2:0] ADDR_RES2   = 3'd2;
   localparam logic [2:0] ADDR_RES3   = 3'd3;
   localparam logic [2:0] ADDR_STATUS = 3'd4;

   // Status word bit positions.
   localparam int unsigned BUSY_BIT    = 0;
   localparam int unsigned DONE_BIT    = 1;
   localparam int unsigned TIMEOUT_BIT = 2;

endpackage

// File: rtl/aes_word_regfile.sv
// Purpose : 4 x 32-bit word-addressed write register packed into 128 bits.
// Latency : a write appears on q the cycle after wr_en.
// Backpressure: none; the caller gates wr_en when the value must stay stable.
// Ports: clk, reset_n (async active-low), wr_en/wr_addr/wr_data write port,
//        q = {word0, word1, word2, word3} (word 0 in bits 127:96).
module aes_word_regfile (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         wr_en,
   input  logic [1:0]   wr_addr,
   input  logic [31:0]  wr_data,
   output logic [127:0] q
);

   logic [31:0] words [4];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 4; i++) begin
            words[i] <= '0;
         end
      end else if (wr_en) begin
         words[wr_addr] <= wr_data;
      end
   end

   assign q = {words[0], words[1], words[2], words[3]};

endmodule

// File: rtl/aes_io_loader.sv
// Purpose : bus-side front end for the AES controller: loads msg/key words,
//           runs the io_ready/aes_ready handshake, captures and exposes the result.
// Latency : io_ready rises the edge after start; rd_data lags rd_addr by one cycle.
// Backpressure: writes/start are dropped while an operation is in flight.
// Ports: clk, reset_n; wr_en/wr_addr/wr_data, start, rd_addr/rd_data (bus side);
//        busy, done status; msg_en, key, io_ready out and msg_de, aes_ready in
//        (controller side).
// Option: define AES_IO_TIMEOUT_EN to build the TIMEOUT_CYCLES watchdog on REQ.
module aes_io_loader
   import aes_io_pkg::*;
#(
   parameter logic [19:0] TIMEOUT_CYCLES = 20'd1000000
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         wr_en,
   input  logic [2:0]   wr_addr,
   input  logic [31:0]  wr_data,
   input  logic         start,
   input  logic [2:0]   rd_addr,
   output logic [31:0]  rd_data,
   output logic         busy,
   output logic         done,
   output logic [127:0] msg_en,
   output logic [127:0] key,
   input  logic [127:0] msg_de,
   output logic         io_ready,
   input  logic         aes_ready
);

   state_t       state;
   logic [127:0] result;
   logic         timeout_flag;
   logic         wr_ok;
   logic         limit_hit;
   logic [31:0]  status_word;

   // Writes only land in IDLE so the controller sees stable operands in REQ.
   // A write coinciding with start still lands, on the same edge io_ready rises.
   assign wr_ok = wr_en && (state == ST_IDLE);

   // Address bit 2 selects key (4-7) versus message (0-3).
   aes_word_regfile u_msg (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (wr_ok && !wr_addr[2]),
      .wr_addr (wr_addr[1:0]),
      .wr_data (wr_data),
      .q       (msg_en)
   );

   aes_word_regfile u_key (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (wr_ok && wr_addr[2]),
      .wr_addr (wr_addr[1:0]),
      .wr_data (wr_data),
      .q       (key)
   );

`ifdef AES_IO_TIMEOUT_EN
   logic [19:0] wait_cnt;

   // Cleared on the edge that enters REQ, so it reads N-1 in the Nth REQ cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wait_cnt <= '0;
      end else if (state == ST_IDLE && start) begin
         wait_cnt <= '0;
      end else if (state == ST_REQ) begin
         wait_cnt <= wait_cnt + 20'd1;
      end
   end

   assign limit_hit = (wait_cnt == TIMEOUT_CYCLES - 20'd1);
`else
   logic unused_timeout_cfg;

   assign limit_hit          = 1'b0;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_IDLE;
         io_ready     <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         timeout_flag <= 1'b0;
         result       <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state        <= ST_REQ;
                  io_ready     <= 1'b1;
                  busy         <= 1'b1;
                  done         <= 1'b0;
                  timeout_flag <= 1'b0;
               end
            end
            ST_REQ: begin
               // aes_ready takes priority over a watchdog expiry on the same cycle.
               if (aes_ready) begin
                  result   <= msg_de;
                  io_ready <= 1'b0;
                  state    <= ST_CAPTURE;
               end else if (limit_hit) begin
                  io_ready     <= 1'b0;
                  busy         <= 1'b0;
                  timeout_flag <= 1'b1;
                  state        <= ST_IDLE;
               end
            end
            ST_CAPTURE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               io_ready <= 1'b0;
               busy     <= 1'b0;
               state    <= ST_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      status_word              = '0;
      status_word[BUSY_BIT]    = busy;
      status_word[DONE_BIT]    = done;
      status_word[TIMEOUT_BIT] = timeout_flag;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_data <= '0;
      end else begin
         case (rd_addr)
            ADDR_RES0:   rd_data <= result[127:96];
            ADDR_RES1:   rd_data <= result[95:64];
            ADDR_RES2:   rd_data <= result[63:32];
            ADDR_RES3:   rd_data <= result[31:0];
            ADDR_STATUS: rd_data <= status_word;
            default:     rd_data <= '0;
         endcase
      end
   end

endmodule
